// File: rtl/fp32_to_int32.sv
// Two-stage pipelined IEEE-754 binary32 to signed int32 converter with valid/ready on both sides.
// Define F2I_ROUND_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module fp32_to_int32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);

  localparam logic [7:0]  ExpIntMax = 8'd158;
  localparam logic [7:0]  ExpTiny   = 8'd95;
  localparam logic [31:0] MinIntBits = 32'hCF00_0000;
  localparam logic [31:0] PosSat    = 32'h7FFF_FFFF;
  localparam logic [31:0] NegSat    = 32'h8000_0000;

  // Handshake
  logic s1_valid;
  logic s2_load;
  logic in_fire;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  // Stage 1: unpack and classify
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic [5:0]  sh_d;
  logic        zero_d;
  logic        nan_d;
  logic        inf_d;
  logic        ovf_d;

  assign in_exp  = in_data[30:23];
  assign in_frac = in_data[22:0];

  always_comb begin
    sh_d = 6'd0;
    if (in_exp >= ExpIntMax) begin
      sh_d = 6'd0;
    end else if (in_exp < ExpTiny) begin
      sh_d = 6'd63;
    end else begin
      sh_d = 6'(ExpIntMax - in_exp);
    end
  end

  always_comb begin
    zero_d = (in_exp == 8'd0);
    nan_d  = (in_exp == 8'hFF) && (in_frac != 23'd0);
    inf_d  = (in_exp == 8'hFF) && (in_frac == 23'd0);
    // Exactly -2^31 is the one representable operand at the top exponent.
    ovf_d  = (in_exp >= ExpIntMax) && (in_exp != 8'hFF) && (in_data != MinIntBits);
  end

  logic        s1_sign;
  logic [31:0] s1_mant;
  logic [5:0]  s1_sh;
  logic        s1_zero;
  logic        s1_nan;
  logic        s1_inf;
  logic        s1_ovf;
  logic        s1_frac_nz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_mant    <= 32'd0;
      s1_sh      <= 6'd0;
      s1_zero    <= 1'b0;
      s1_nan     <= 1'b0;
      s1_inf     <= 1'b0;
      s1_ovf     <= 1'b0;
      s1_frac_nz <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid   <= 1'b1;
        s1_sign    <= in_data[31];
        s1_mant    <= {1'b1, in_frac, 8'd0};
        s1_sh      <= sh_d;
        s1_zero    <= zero_d;
        s1_nan     <= nan_d;
        s1_inf     <= inf_d;
        s1_ovf     <= ovf_d;
        s1_frac_nz <= (in_frac != 23'd0);
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: de-normalize, round, negate, saturate
  logic [63:0] shifted;
  logic [31:0] int_part;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [32:0] mag;
  logic        sat;
  logic [31:0] signed_val;
  logic [31:0] res_d;
  logic        invalid_d;
  logic        inexact_d;

  assign shifted = {s1_mant, 32'd0} >> s1_sh;

  always_comb begin
    int_part = shifted[63:32];
    guard    = shifted[31];
    sticky   = |shifted[30:0];
    if (s1_zero) begin
      int_part = 32'd0;
      guard    = 1'b0;
      sticky   = s1_frac_nz;
    end
  end

`ifdef F2I_ROUND_EN
  assign inc = guard && (sticky || int_part[0]);
`else
  assign inc = 1'b0;
`endif

  always_comb begin
    mag        = {1'b0, int_part} + {32'd0, inc};
    sat        = s1_sign ? (mag > {1'b0, NegSat}) : (mag > {1'b0, PosSat});
    signed_val = s1_sign ? (32'd0 - mag[31:0]) : mag[31:0];
  end

  always_comb begin
    res_d     = signed_val;
    invalid_d = 1'b0;
    if (s1_nan) begin
      res_d     = PosSat;
      invalid_d = 1'b1;
    end else if (s1_inf || s1_ovf || sat) begin
      res_d     = s1_sign ? NegSat : PosSat;
      invalid_d = 1'b1;
    end
    inexact_d = (guard || sticky) && !invalid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= 32'd0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data    <= res_d;
        out_invalid <= invalid_d;
        out_inexact <= inexact_d;
      end
    end
  end

endmodule

// File: tb/tb_fp32_to_int32.sv
// Bench for fp32_to_int32: directed vectors, back-pressure, reset and randomized traffic
// scored against an arithmetic reference model.
module tb_fp32_to_int32;

`ifdef F2I_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_invalid;
  logic        out_inexact;

  always #5 clk = ~clk;

  fp32_to_int32 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_invalid(out_invalid),
    .out_inexact(out_inexact)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [33:0] exp_q[$];   // {invalid, inexact, data}
  logic        prev_hold = 1'b0;
  logic [33:0] prev_out = '0;
  logic        acc;
  logic        got;

  task automatic check(input string tag, input logic [33:0] seen, input logic [33:0] want);
    n_cmp++;
    if (seen !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, seen, want);
    end
  endtask

  // Reference: value = 1.f * 2^(e-150), rounded with plain integer arithmetic.
  function automatic logic [33:0] ref_conv(input logic [31:0] x);
    logic               s;
    int                 e;
    int                 d;
    longint unsigned    sig;
    longint unsigned    q;
    longint unsigned    rem;
    longint unsigned    half;
    longint unsigned    mag;
    longint unsigned    limit;
    logic               inx;
    logic               up;
    logic [31:0]        m32;
    s   = x[31];
    e   = int'(x[30:23]);
    sig = longint'({1'b1, x[22:0]});
    if (e == 255) return {2'b10, ((x[22:0] != 23'd0) || !s) ? 32'h7FFF_FFFF : 32'h8000_0000};
    if (e == 0) return {1'b0, (x[22:0] != 23'd0), 32'd0};
    if (e > 158) return {2'b10, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
    up  = 1'b0;
    inx = 1'b0;
    if (e >= 150) begin
      mag = sig << (e - 150);
    end else begin
      d = 150 - e;
      if (d > 25) begin
        mag = 0;
        inx = 1'b1;
      end else begin
        q    = sig >> d;
        rem  = sig - (q << d);
        half = 64'd1 << (d - 1);
        mag  = q;
        inx  = (rem != 0);
        up   = (rem > half) || ((rem == half) && q[0]);
      end
    end
    if (RoundEn && up) mag = mag + 1;
    limit = s ? 64'h8000_0000 : 64'h7FFF_FFFF;
    if (mag > limit) return {2'b10, s ? 32'h8000_0000 : 32'h7FFF_FFFF};
    m32 = mag[31:0];
    return {1'b0, inx, s ? (32'd0 - m32) : m32};
  endfunction

  // One clock cycle: drive at negedge, sample 1 ns later, score transfers that the next edge makes.
  task automatic step(input logic v, input logic [31:0] d, input logic [33:0] want, input logic r,
                      output logic a, output logic g);
    logic [33:0] w;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    if (prev_hold) begin
      check("hold_valid", 34'(out_valid), 34'd1);
      check("hold_word", {out_invalid, out_inexact, out_data}, prev_out);
    end
    a = in_valid && in_ready;
    g = out_valid && out_ready;
    if (g) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 34'(out_valid && out_ready), 34'd0);
      end else begin
        w = exp_q.pop_front();
        check("data", 34'(out_data), 34'(w[31:0]));
        check("invalid", 34'(out_invalid), 34'(w[33]));
        check("inexact", 34'(out_inexact), 34'(w[32]));
      end
    end
    if (a) exp_q.push_back(want);
    prev_hold = out_valid && !out_ready;
    prev_out  = {out_invalid, out_inexact, out_data};
  endtask

  task automatic idle(input logic r);
    step(1'b0, 32'd0, 34'd0, r, acc, got);
  endtask

  // Operand accepted in one cycle must be visible two cycles later, not one.
  task automatic latency_probe(input logic [31:0] x, input logic [33:0] want);
    step(1'b1, x, want, 1'b1, acc, got);
    check("lat_accept", 34'(acc), 34'd1);
    idle(1'b1);
    check("lat_early", 34'(got), 34'd0);
    idle(1'b1);
    check("lat_arrive", 34'(got), 34'd1);
  endtask

  logic [31:0] dir_in  [11];
  logic [33:0] dir_exp [11];
  logic [31:0] bp_in   [4];
  int          n_acc;
  int          n_got;
  int          idx;
  logic [31:0] x;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dir_in[0]  = 32'h3FC0_0000; dir_exp[0]  = RoundEn ? {2'b01, 32'd2} : {2'b01, 32'd1};
    dir_in[1]  = 32'h4020_0000; dir_exp[1]  = {2'b01, 32'd2};
    dir_in[2]  = 32'hC020_0000; dir_exp[2]  = {2'b01, 32'hFFFF_FFFE};
    dir_in[3]  = 32'h4F00_0000; dir_exp[3]  = {2'b10, 32'h7FFF_FFFF};
    dir_in[4]  = 32'hCF00_0000; dir_exp[4]  = {2'b00, 32'h8000_0000};
    dir_in[5]  = 32'h7FC0_0000; dir_exp[5]  = {2'b10, 32'h7FFF_FFFF};
    dir_in[6]  = 32'hFF80_0000; dir_exp[6]  = {2'b10, 32'h8000_0000};
    dir_in[7]  = 32'h0000_0001; dir_exp[7]  = {2'b01, 32'd0};
    dir_in[8]  = 32'h8000_0000; dir_exp[8]  = {2'b00, 32'd0};
    dir_in[9]  = 32'h4EFF_FFFF; dir_exp[9]  = {2'b00, 32'h7FFF_FF80};
    dir_in[10] = 32'h3F80_0000; dir_exp[10] = {2'b00, 32'd1};
    bp_in[0] = 32'h3F80_0000;
    bp_in[1] = 32'h4000_0000;
    bp_in[2] = 32'h4040_0000;
    bp_in[3] = 32'h4080_0000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 34'(out_valid), 34'd0);
    check("rst_in_ready", 34'(in_ready), 34'd1);
    check("rst_out_word", {out_invalid, out_inexact, out_data}, 34'd0);
    rst = 1'b0;

    // Directed vectors back-to-back
    for (int i = 0; i < 11; i++) step(1'b1, dir_in[i], dir_exp[i], 1'b1, acc, got);
    repeat (4) idle(1'b1);

    latency_probe(32'h4120_0000, {2'b00, 32'd10});
    idle(1'b1);

    // Back-pressure: 3 stalled cycles, then release
    n_acc = 0;
    n_got = 0;
    idx   = 0;
    for (int c = 0; c < 7; c++) begin
      step(idx < 4, (idx < 4) ? bp_in[idx] : 32'd0, {2'b00, 32'(idx + 1)}, c >= 3, acc, got);
      if (acc) idx++;
      if (c < 3) n_acc += int'(acc);
      if (c == 2) begin
        check("bp_in_ready", 34'(in_ready), 34'd0);
        check("bp_head", 34'(out_data), 34'd1);
        check("bp_accepts", 34'(n_acc), 34'd2);
      end
      if (c >= 3) n_got += int'(got);
    end
    check("bp_stream", 34'(n_got), 34'd4);
    check("bp_fed", 34'(idx), 34'd4);
    repeat (2) idle(1'b1);

    // Reset with both stages full
    step(1'b1, 32'h4040_0000, {2'b00, 32'd3}, 1'b0, acc, got);
    step(1'b1, 32'h4080_0000, {2'b00, 32'd4}, 1'b0, acc, got);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_out_valid", 34'(out_valid), 34'd0);
    check("midrst_in_ready", 34'(in_ready), 34'd1);
    exp_q.delete();
    prev_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_got = 0;
    for (int c = 0; c < 3; c++) begin
      idle(1'b1);
      n_got += int'(got);
    end
    check("midrst_no_stale", 34'(n_got), 34'd0);
    latency_probe(32'h4120_0000, {2'b00, 32'd10});
    idle(1'b1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      x = $urandom;
      if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(110, 160));
      else if ($urandom_range(0, 7) == 0) x[30:23] = 8'($urandom_range(0, 1) * 255);
      step($urandom_range(0, 3) != 0, x, ref_conv(x), $urandom_range(0, 9) < 7, acc, got);
    end
    for (int c = 0; c < 8; c++) idle(1'b1);
    check("drain_empty", 34'(exp_q.size()), 34'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
